// File: rtl/scg_lock_supervisor_if.sv
// Status/control bundle between the system clock generator's lock supervisor and
// the surrounding logic (clock IP reset, system reset, status reporting).
// The supervisor connects through the master modport; the other side connects through slave.
interface scg_lock_supervisor_if;
   logic       locked_i;
   logic       pll_rst_o;
   logic       sys_rst_o;
   logic       ready_o;
   logic       timeout_o;
   logic [1:0] state_o;
   logic [7:0] lol_cnt_o;

   modport master (
      input  locked_i,
      output pll_rst_o,
      output sys_rst_o,
      output ready_o,
      output timeout_o,
      output state_o,
      output lol_cnt_o
   );

   modport slave (
      output locked_i,
      input  pll_rst_o,
      input  sys_rst_o,
      input  ready_o,
      input  timeout_o,
      input  state_o,
      input  lol_cnt_o
   );
endinterface

// File: rtl/scg_lock_supervisor.sv
// Lock supervisor for the system clock generator. It pulses the clock IP reset,
// waits for LOCKED (retrying on timeout), qualifies lock for STABLE_CYCLES and only
// then releases the system reset. A loss of lock in RUN re-asserts the system reset.
// Optional macro SCG_LOL_COUNT_EN adds an 8-bit saturating loss-of-lock counter;
// without it lol_cnt_o is tied to zero.
module scg_lock_supervisor #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 100000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned CNT_W          = 17
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   scg_lock_supervisor_if.master bus
);

   typedef enum logic [1:0] {
      StRstPll   = 2'd0,
      StWaitLock = 2'd1,
      StStable   = 2'd2,
      StRun      = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] PllLast     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);

   logic             r_meta;
   logic             r_locked_s;
   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timeout_nxt;
   logic             w_pll_rst_nxt;
   logic             w_sys_rst_nxt;
   logic             r_pll_rst;
   logic             r_sys_rst;
   logic             r_ready;
   logic             r_timeout;

   // Two-flop synchronizer for the asynchronous LOCKED input.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_meta     <= 1'b0;
         r_locked_s <= 1'b0;
      end else begin
         r_meta     <= bus.locked_i;
         r_locked_s <= r_meta;
      end
   end

   // State and phase counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= StRstPll;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic; the counter restarts from zero on every state change.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt + 1'b1;
      w_timeout_nxt = 1'b0;
      unique case (r_state)
         StRstPll: begin
            if (r_cnt == PllLast) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = '0;
            end
         end
         StWaitLock: begin
            // Lock takes priority over a coincident timeout.
            if (r_locked_s) begin
               w_state_nxt = StStable;
               w_cnt_nxt   = '0;
            end else if (r_cnt == TimeoutLast) begin
               w_state_nxt   = StRstPll;
               w_cnt_nxt     = '0;
               w_timeout_nxt = 1'b1;
            end
         end
         StStable: begin
            // A glitch only restarts qualification; the PLL is not reset.
            if (!r_locked_s) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = '0;
            end else if (r_cnt == StableLast) begin
               w_state_nxt = StRun;
               w_cnt_nxt   = '0;
            end
         end
         StRun: begin
            w_cnt_nxt = '0;
            if (!r_locked_s) begin
               w_state_nxt = StWaitLock;
            end
         end
         default: begin
            w_state_nxt = StRstPll;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Output decode from the next state so the registered outputs change on the same edge.
   always_comb begin
      w_pll_rst_nxt = (w_state_nxt == StRstPll);
      w_sys_rst_nxt = (w_state_nxt != StRun);
   end

   // Registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_pll_rst <= w_pll_rst_nxt;
         r_sys_rst <= w_sys_rst_nxt;
         r_ready   <= ~w_sys_rst_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

`ifdef SCG_LOL_COUNT_EN
   logic [7:0] r_lol_cnt;
   logic       w_lol_evt;

   assign w_lol_evt = (r_state == StRun) && !r_locked_s;

   // Saturating loss-of-lock event counter, cleared only by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lol_cnt <= 8'd0;
      end else if (w_lol_evt && (r_lol_cnt != 8'hff)) begin
         r_lol_cnt <= r_lol_cnt + 8'd1;
      end
   end

   assign bus.lol_cnt_o = r_lol_cnt;
`else
   assign bus.lol_cnt_o = 8'd0;
`endif

   assign bus.pll_rst_o = r_pll_rst;
   assign bus.sys_rst_o = r_sys_rst;
   assign bus.ready_o   = r_ready;
   assign bus.timeout_o = r_timeout;
   assign bus.state_o   = r_state;

endmodule

// File: tb/tb_scg_lock_supervisor.sv
// Directed bench for scg_lock_supervisor with small timing parameters.
// Expected output vectors are queued as each step is driven and compared once the
// step's clock edges have elapsed.
module tb_scg_lock_supervisor;

   logic clk_i;
   logic rst_i;

   scg_lock_supervisor_if u_if ();

   scg_lock_supervisor #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (16),
      .STABLE_CYCLES  (8),
      .CNT_W          (5)
   ) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (u_if.master)
   );

   typedef struct {
      string       tag;
      logic [13:0] vec;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp;
   int   n_bad;
   int   exp_lol;
   bit   lol_on;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Record one loss-of-lock event seen from RUN in the expectation model.
   task automatic note_loss();
      if (lol_on && exp_lol < 255) exp_lol++;
   endtask

   // Queue the expected outputs, run n edges, then pop and compare.
   task automatic step(input int n, input string tag, input logic [1:0] st,
                       input logic pll, input logic sys, input logic to);
      exp_t e;
      exp_t p;
      logic [13:0] obs;
      e.tag = tag;
      e.vec = {st, pll, sys, ~sys, to, 8'(exp_lol)};
      sb_q.push_back(e);
      cyc(n);
      p   = sb_q.pop_front();
      obs = {u_if.state_o, u_if.pll_rst_o, u_if.sys_rst_o, u_if.ready_o,
             u_if.timeout_o, u_if.lol_cnt_o};
      n_cmp++;
      assert (obs === p.vec) else begin
         n_bad++;
         $error("FAIL %s observed={st,pll,sys,rdy,to,lol}=%h expected=%h", p.tag, obs, p.vec);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      exp_lol = 0;
`ifdef SCG_LOL_COUNT_EN
      lol_on  = 1'b1;
`else
      lol_on  = 1'b0;
`endif
      rst_i          = 1'b1;
      u_if.locked_i  = 1'b1;

      // Reset values, locked high from the start.
      step(3, "reset", 2'd0, 1'b1, 1'b1, 1'b0);
      rst_i = 1'b0;
      step(3, "pll_hold", 2'd0, 1'b1, 1'b1, 1'b0);
      step(1, "wait_entry", 2'd1, 1'b0, 1'b1, 1'b0);
      step(1, "stable_entry", 2'd2, 1'b0, 1'b1, 1'b0);
      step(7, "stable_hold", 2'd2, 1'b0, 1'b1, 1'b0);
      step(1, "run_entry", 2'd3, 1'b0, 1'b0, 1'b0);

      // One-cycle lock drop in RUN.
      u_if.locked_i = 1'b0;
      cyc(1);
      u_if.locked_i = 1'b1;
      step(1, "run_sync_delay", 2'd3, 1'b0, 1'b0, 1'b0);
      note_loss();
      step(1, "run_loss", 2'd1, 1'b0, 1'b1, 1'b0);
      step(1, "requal", 2'd2, 1'b0, 1'b1, 1'b0);
      step(7, "requal_hold", 2'd2, 1'b0, 1'b1, 1'b0);
      step(1, "rerun", 2'd3, 1'b0, 1'b0, 1'b0);

      // Reach STABLE again, then glitch while the counter is 5.
      u_if.locked_i = 1'b0;
      cyc(1);
      u_if.locked_i = 1'b1;
      step(1, "run_sync_delay2", 2'd3, 1'b0, 1'b0, 1'b0);
      note_loss();
      step(1, "run_loss2", 2'd1, 1'b0, 1'b1, 1'b0);
      step(1, "stable2", 2'd2, 1'b0, 1'b1, 1'b0);
      cyc(3);
      u_if.locked_i = 1'b0;
      cyc(1);
      u_if.locked_i = 1'b1;
      step(1, "stable_cnt5", 2'd2, 1'b0, 1'b1, 1'b0);
      step(1, "stable_glitch", 2'd1, 1'b0, 1'b1, 1'b0);
      step(1, "requal2", 2'd2, 1'b0, 1'b1, 1'b0);
      step(7, "requal2_hold", 2'd2, 1'b0, 1'b1, 1'b0);
      step(1, "rerun2", 2'd3, 1'b0, 1'b0, 1'b0);

      // Permanent loss: timeout after 16 WAIT_LOCK cycles, PLL reset for 4.
      u_if.locked_i = 1'b0;
      step(1, "run_before_loss", 2'd3, 1'b0, 1'b0, 1'b0);
      note_loss();
      step(2, "run_loss3", 2'd1, 1'b0, 1'b1, 1'b0);
      step(15, "wait_last", 2'd1, 1'b0, 1'b1, 1'b0);
      step(1, "timeout_pulse", 2'd0, 1'b1, 1'b1, 1'b1);
      step(1, "timeout_end", 2'd0, 1'b1, 1'b1, 1'b0);
      step(2, "pll_rehold", 2'd0, 1'b1, 1'b1, 1'b0);
      step(1, "wait_again", 2'd1, 1'b0, 1'b1, 1'b0);
      step(13, "wait_cnt13", 2'd1, 1'b0, 1'b1, 1'b0);

      // Lock arrives at the FSM exactly when the counter reads 15.
      u_if.locked_i = 1'b1;
      step(2, "wait_cnt15", 2'd1, 1'b0, 1'b1, 1'b0);
      step(1, "lock_wins", 2'd2, 1'b0, 1'b1, 1'b0);
      step(7, "latency_hold", 2'd2, 1'b0, 1'b1, 1'b0);
      step(1, "run_latency", 2'd3, 1'b0, 1'b0, 1'b0);

      // 300 RUN loss events drive the counter into saturation.
      for (int k = 0; k < 300; k++) begin
         u_if.locked_i = 1'b0;
         cyc(1);
         u_if.locked_i = 1'b1;
         note_loss();
         cyc(11);
      end
      step(0, "lol_saturate", 2'd3, 1'b0, 1'b0, 1'b0);

      // One more loss (still saturated), then reset asynchronously mid-STABLE.
      u_if.locked_i = 1'b0;
      cyc(1);
      u_if.locked_i = 1'b1;
      note_loss();
      step(3, "stable_final", 2'd2, 1'b0, 1'b1, 1'b0);
      cyc(2);
      #3;
      rst_i = 1'b1;
      #1;
      exp_lol = 0;
      step(0, "async_reset", 2'd0, 1'b1, 1'b1, 1'b0);
      step(2, "reset_hold", 2'd0, 1'b1, 1'b1, 1'b0);
      rst_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
